// File: rtl/operand_skew_buffer.sv
// operand_skew_buffer
//   Stages N operand words (one A row + one B row each) and replays them as
//   diagonally skewed wavefronts over 2N-1 read steps. At step t, A lane i
//   carries A[i][t-i] and B lane j carries B[t-j][j], or 0 outside the matrix.
//   The result is that PE(i,j) sees A[i][k] and B[k][j] on the same cycle.
// Ports
//   i_clk, i_rst_n     clock, async active-low hard reset
//   buff_rst_n         sync active-low soft clear (counters + lanes)
//   buff_wr, i_wr_data write strobe; word = {B row, A row}, element 0 at LSB
//   buff_rd            read-step strobe (1-cycle latency to lanes)
//   o_a_lanes          lane i -> array row i
//   o_b_lanes          lane j -> array column j
//   o_lanes_valid      lanes hold a read step this cycle
//   buff_is_full       all N words stored
//   buff_is_empty      no read step available (includes partial fill)
//   o_wr_count         words stored

// Picks src[t-LANE] when that index is inside the vector, else 0.
module operand_skew_lane #(
  parameter int N    = 4,
  parameter int DW   = 8,
  parameter int LANE = 0,
  parameter int SW   = 3
) (
  input  logic [SW-1:0]         step,
  input  logic [N-1:0][DW-1:0]  src,
  output logic [DW-1:0]         elem
);
  always_comb begin
    elem = '0;
    for (int k = 0; k < N; k++)
      if (int'(step) == LANE + k) elem = src[k];
  end
endmodule

module operand_skew_buffer #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     buff_rst_n,
  input  logic                     buff_wr,
  input  logic [2*N*DW-1:0]        i_wr_data,
  input  logic                     buff_rd,
  output logic [N*DW-1:0]          o_a_lanes,
  output logic [N*DW-1:0]          o_b_lanes,
  output logic                     o_lanes_valid,
  output logic                     buff_is_full,
  output logic                     buff_is_empty,
  output logic [$clog2(N+1)-1:0]   o_wr_count
);
  localparam int CW   = $clog2(N+1);
  localparam int SW   = $clog2(2*N);
  localparam int LAST = 2*N-1;

  // [row][element]
  logic [N-1:0][N-1:0][DW-1:0] a_mem, b_mem;
  // b_mem transposed: [column][k], so each B lane walks down its column
  logic [N-1:0][N-1:0][DW-1:0] b_col;

  logic [CW-1:0]          wr_cnt;
  logic [SW-1:0]          rd_step;
  logic [N-1:0][DW-1:0]   wr_a, wr_b;
  logic [N-1:0][DW-1:0]   a_nxt, b_nxt, a_q, b_q;
  logic                   vld_q;
  logic                   full, empty, wr_acc, rd_acc;

  assign wr_a = i_wr_data[N*DW-1:0];
  assign wr_b = i_wr_data[2*N*DW-1:N*DW];

  assign full   = (wr_cnt == CW'(N));
  assign empty  = !full || (rd_step == SW'(LAST));
  // Acceptance hinges on full, so a write and a read never both land.
  assign wr_acc = buff_wr && !full;
  assign rd_acc = buff_rd && !empty;

  for (genvar g = 0; g < N; g++) begin : g_lane
    for (genvar h = 0; h < N; h++) begin : g_tr
      assign b_col[g][h] = b_mem[h][g];
    end
    operand_skew_lane #(.N(N), .DW(DW), .LANE(g), .SW(SW)) u_a (
      .step (rd_step),
      .src  (a_mem[g]),
      .elem (a_nxt[g])
    );
    operand_skew_lane #(.N(N), .DW(DW), .LANE(g), .SW(SW)) u_b (
      .step (rd_step),
      .src  (b_col[g]),
      .elem (b_nxt[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_mem   <= '0;
      b_mem   <= '0;
      wr_cnt  <= '0;
      rd_step <= '0;
      a_q     <= '0;
      b_q     <= '0;
      vld_q   <= 1'b0;
    end else if (!buff_rst_n) begin
      // memory is left alone; it is rewritten before it can be read again
      wr_cnt  <= '0;
      rd_step <= '0;
      a_q     <= '0;
      b_q     <= '0;
      vld_q   <= 1'b0;
    end else begin
      if (wr_acc) begin
        for (int r = 0; r < N; r++)
          if (wr_cnt == CW'(r)) begin
            a_mem[r] <= wr_a;
            b_mem[r] <= wr_b;
          end
        wr_cnt <= wr_cnt + CW'(1);
      end
      // Lanes are not held between reads: a missing read is a zero bubble.
      if (rd_acc) begin
        a_q     <= a_nxt;
        b_q     <= b_nxt;
        vld_q   <= 1'b1;
        rd_step <= rd_step + SW'(1);
      end else begin
        a_q   <= '0;
        b_q   <= '0;
        vld_q <= 1'b0;
      end
    end
  end

  assign o_a_lanes     = a_q;
  assign o_b_lanes     = b_q;
  assign o_lanes_valid = vld_q;
  assign buff_is_full  = full;
  assign buff_is_empty = empty;
  assign o_wr_count    = wr_cnt;
endmodule

// File: tb/tb_operand_skew_buffer.sv
// Bench for operand_skew_buffer (N=4, DW=8): directed scenarios with literal
// expectations plus a matrix-level model compared every falling edge.
module tb_operand_skew_buffer;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = $clog2(N+1);

  logic                 i_clk = 1'b0;
  logic                 i_rst_n = 1'b0;
  logic                 buff_rst_n = 1'b1;
  logic                 buff_wr = 1'b0;
  logic                 buff_rd = 1'b0;
  logic [2*N*DW-1:0]    i_wr_data = '0;
  logic [N*DW-1:0]      o_a_lanes, o_b_lanes;
  logic                 o_lanes_valid, buff_is_full, buff_is_empty;
  logic [CW-1:0]        o_wr_count;

  int errors = 0;
  int checks = 0;

  always #5 i_clk = ~i_clk;

  operand_skew_buffer #(.N(N), .DW(DW)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .buff_rst_n    (buff_rst_n),
    .buff_wr       (buff_wr),
    .i_wr_data     (i_wr_data),
    .buff_rd       (buff_rd),
    .o_a_lanes     (o_a_lanes),
    .o_b_lanes     (o_b_lanes),
    .o_lanes_valid (o_lanes_valid),
    .buff_is_full  (buff_is_full),
    .buff_is_empty (buff_is_empty),
    .o_wr_count    (o_wr_count)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---- model: matrices A/B, word count, step index ----
  logic [DW-1:0]   m_a [N][N];
  logic [DW-1:0]   m_b [N][N];
  int              m_cnt  = 0;
  int              m_step = 0;
  logic            m_vld  = 1'b0;
  logic [N*DW-1:0] m_la = '0, m_lb = '0;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n || !buff_rst_n) begin
      m_cnt <= 0; m_step <= 0; m_vld <= 1'b0; m_la <= '0; m_lb <= '0;
    end else begin
      m_vld <= 1'b0; m_la <= '0; m_lb <= '0;
      if (buff_wr && m_cnt < N) begin
        for (int k = 0; k < N; k++) begin
          m_a[m_cnt][k] <= i_wr_data[k*DW +: DW];
          m_b[m_cnt][k] <= i_wr_data[N*DW + k*DW +: DW];
        end
        m_cnt <= m_cnt + 1;
      end
      if (buff_rd && m_cnt == N && m_step < 2*N-1) begin
        m_vld  <= 1'b1;
        m_step <= m_step + 1;
        for (int i = 0; i < N; i++)
          if (m_step >= i && m_step - i < N) begin
            m_la[i*DW +: DW] <= m_a[i][m_step-i];
            m_lb[i*DW +: DW] <= m_b[m_step-i][i];
          end
      end
    end
  end

  always @(negedge i_clk) begin
    chk("mdl_wr_count", 64'(o_wr_count), 64'(m_cnt));
    chk("mdl_full", 64'(buff_is_full), 64'(m_cnt == N));
    chk("mdl_empty", 64'(buff_is_empty), 64'(m_cnt != N || m_step == 2*N-1));
    chk("mdl_valid", 64'(o_lanes_valid), 64'(m_vld));
    chk("mdl_a_lanes", 64'(o_a_lanes), 64'(m_la));
    chk("mdl_b_lanes", 64'(o_b_lanes), 64'(m_lb));
  end

  // ---- stimulus helpers ----
  task automatic cyc();
    @(posedge i_clk); #1;
  endtask

  function automatic logic [2*N*DW-1:0] mkword(input int r, input int off);
    logic [2*N*DW-1:0] w;
    for (int k = 0; k < N; k++) begin
      w[k*DW +: DW]        = DW'(off + r*4 + k + 1);
      w[N*DW + k*DW +: DW] = DW'(8'h10 + off + r*4 + k);
    end
    return w;
  endfunction

  task automatic write_word(input int r, input int off);
    buff_wr = 1'b1; i_wr_data = mkword(r, off); cyc(); buff_wr = 1'b0;
  endtask

  task automatic soft_clear();
    buff_rst_n = 1'b0; cyc(); buff_rst_n = 1'b1;
  endtask

  int nvalid;

  initial begin
    #12 i_rst_n = 1'b1;
    cyc();
    chk("rst_full", 64'(buff_is_full), 64'(0));
    chk("rst_empty", 64'(buff_is_empty), 64'(1));
    chk("rst_count", 64'(o_wr_count), 64'(0));
    chk("rst_valid", 64'(o_lanes_valid), 64'(0));
    chk("rst_lanes", 64'({o_a_lanes, o_b_lanes}), 64'(0));

    // fill
    for (int r = 0; r < N; r++) begin
      write_word(r, 0);
      chk("fill_count", 64'(o_wr_count), 64'(r+1));
    end
    chk("fill_full", 64'(buff_is_full), 64'(1));
    chk("fill_empty", 64'(buff_is_empty), 64'(0));
    write_word(0, 8'h80);
    chk("extra_wr_count", 64'(o_wr_count), 64'(4));

    // skewed drain, rd held 8 cycles
    buff_rd = 1'b1; nvalid = 0;
    for (int c = 0; c < 8; c++) begin
      cyc();
      if (o_lanes_valid) nvalid++;
      if (c == 0) begin
        chk("s0_a", 64'(o_a_lanes), 64'(32'h00000001));
        chk("s0_b", 64'(o_b_lanes), 64'(32'h00000010));
      end
      if (c == 3) begin
        chk("s3_a", 64'(o_a_lanes), 64'(32'h0D0A0704));
        chk("s3_b", 64'(o_b_lanes), 64'(32'h1316191C));
      end
      if (c == 6) begin
        chk("s6_a", 64'(o_a_lanes), 64'(32'h10000000));
        chk("s6_b", 64'(o_b_lanes), 64'(32'h1F000000));
        chk("s6_empty", 64'(buff_is_empty), 64'(1));
      end
      if (c == 7) chk("s7_valid", 64'(o_lanes_valid), 64'(0));
    end
    buff_rd = 1'b0;
    chk("drain_steps", 64'(nvalid), 64'(7));

    // read before full, then drain with bubbles
    soft_clear();
    write_word(0, 0); write_word(1, 0);
    buff_rd = 1'b1; cyc(); buff_rd = 1'b0;
    chk("early_rd_valid", 64'(o_lanes_valid), 64'(0));
    chk("early_rd_lanes", 64'({o_a_lanes, o_b_lanes}), 64'(0));
    write_word(2, 0); write_word(3, 0);
    nvalid = 0;
    for (int c = 0; c < 14; c++) begin
      buff_rd = (c % 2 == 0);
      cyc();
      if (o_lanes_valid) nvalid++;
      if (c % 2 == 1) chk("bubble_valid", 64'(o_lanes_valid), 64'(0));
      if (c == 0) chk("gap_s0_a", 64'(o_a_lanes), 64'(32'h00000001));
      if (c == 6) chk("gap_s3_b", 64'(o_b_lanes), 64'(32'h1316191C));
      if (c == 12) chk("gap_s6_a", 64'(o_a_lanes), 64'(32'h10000000));
    end
    buff_rd = 1'b0;
    chk("gap_steps", 64'(nvalid), 64'(7));

    // soft clear at drain step 3 together with a read
    soft_clear();
    for (int r = 0; r < N; r++) write_word(r, 0);
    buff_rd = 1'b1;
    cyc(); cyc(); cyc();
    buff_rst_n = 1'b0; cyc(); buff_rst_n = 1'b1; buff_rd = 1'b0;
    chk("clr_valid", 64'(o_lanes_valid), 64'(0));
    chk("clr_lanes", 64'({o_a_lanes, o_b_lanes}), 64'(0));
    chk("clr_count", 64'(o_wr_count), 64'(0));
    chk("clr_full", 64'(buff_is_full), 64'(0));
    chk("clr_empty", 64'(buff_is_empty), 64'(1));
    buff_rst_n = 1'b0; buff_wr = 1'b1; i_wr_data = mkword(0, 8'h60);
    cyc();
    buff_rst_n = 1'b1; buff_wr = 1'b0;
    chk("clr_wr_count", 64'(o_wr_count), 64'(0));
    for (int r = 0; r < N; r++) write_word(r, 8'h20);
    buff_rd = 1'b1; cyc();
    chk("refill_s0_a", 64'(o_a_lanes), 64'(32'h00000021));
    chk("refill_s0_b", 64'(o_b_lanes), 64'(32'h00000030));
    cyc();

    // async reset mid-cycle during drain
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(o_lanes_valid), 64'(0));
    chk("arst_lanes", 64'({o_a_lanes, o_b_lanes}), 64'(0));
    chk("arst_count", 64'(o_wr_count), 64'(0));
    chk("arst_full", 64'(buff_is_full), 64'(0));
    chk("arst_empty", 64'(buff_is_empty), 64'(1));
    buff_rd = 1'b0;
    cyc();
    #2 i_rst_n = 1'b1;
    cyc();
    for (int r = 0; r < N; r++) write_word(r, 8'h40);
    buff_rd = 1'b1; cyc(); buff_rd = 1'b0;
    chk("post_rst_s0_a", 64'(o_a_lanes), 64'(32'h00000041));
    chk("post_rst_s0_b", 64'(o_b_lanes), 64'(32'h00000050));
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
